// File: rtl/decode_queue.sv
// decode_queue: decodes 32-bit MIPS-style instruction words at the input and
// buffers the decoded control/field bundle in a QDEPTH-entry circular FIFO.
// Also keeps a saturating count of illegal instructions accepted.
// Optional feature: define DECODE_QUEUE_FUNCT_EN to decode R_type funct codes
// and produce ALU operation codes (otherwise out_alu_op is constant 0).
module decode_queue #(
  parameter int QDEPTH = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [11:0]      out_ctrl,
  output logic             out_illegal,
  output logic [3:0]       out_alu_op,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_rd,
  output logic [15:0]      out_imm,
  output logic [25:0]      out_target,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int OCC_W = $clog2(QDEPTH) + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(QDEPTH);

  // One-hot class bit positions in out_ctrl
  localparam int C_RTYPE = 0;
  localparam int C_ADDI  = 1;
  localparam int C_ANDI  = 2;
  localparam int C_ORI   = 3;
  localparam int C_XORI  = 4;
  localparam int C_LW    = 5;
  localparam int C_SW    = 6;
  localparam int C_BEQ   = 7;
  localparam int C_BNE   = 8;
  localparam int C_LUI   = 9;
  localparam int C_J     = 10;
  localparam int C_JAL   = 11;

  typedef struct packed {
    logic [11:0] ctrl;
    logic        illegal;
    logic [3:0]  alu_op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;
  } entry_t;

  entry_t            mem_reg [QDEPTH];
  entry_t            dec_entry;
  entry_t            head_entry;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [OCC_W-1:0]  occ_reg;
  logic [CNT_W-1:0]  illegal_cnt_reg;
  logic [5:0]        opcode;
  logic              push;
  logic              pop;

  assign opcode    = in_instr[31:26];
  assign in_ready  = (occ_reg < FULL_OCC);
  assign out_valid = (occ_reg != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Decode the incoming word into class, legality, ALU op and fields
  always_comb begin
    dec_entry        = '0;
    dec_entry.rs     = in_instr[25:21];
    dec_entry.rt     = in_instr[20:16];
    dec_entry.rd     = in_instr[15:11];
    dec_entry.imm    = in_instr[15:0];
    dec_entry.target = in_instr[25:0];
    case (opcode)
      6'b000000: begin
`ifdef DECODE_QUEUE_FUNCT_EN
        case (in_instr[5:0])
          6'b100000: dec_entry.alu_op = 4'd0;
          6'b100010: dec_entry.alu_op = 4'd1;
          6'b100100: dec_entry.alu_op = 4'd2;
          6'b100101: dec_entry.alu_op = 4'd3;
          6'b100110: dec_entry.alu_op = 4'd4;
          6'b101010: dec_entry.alu_op = 4'd5;
          6'b000000: dec_entry.alu_op = 4'd6;
          6'b000010: dec_entry.alu_op = 4'd7;
          default:   dec_entry.illegal = 1'b1;
        endcase
        // An unknown funct leaves the class vector empty
        dec_entry.ctrl[C_RTYPE] = !dec_entry.illegal;
`else
        dec_entry.ctrl[C_RTYPE] = 1'b1;
`endif
      end
      6'b001000: dec_entry.ctrl[C_ADDI] = 1'b1;
      6'b001100: begin
        dec_entry.ctrl[C_ANDI] = 1'b1;
`ifdef DECODE_QUEUE_FUNCT_EN
        dec_entry.alu_op = 4'd2;
`endif
      end
      6'b001101: begin
        dec_entry.ctrl[C_ORI] = 1'b1;
`ifdef DECODE_QUEUE_FUNCT_EN
        dec_entry.alu_op = 4'd3;
`endif
      end
      6'b001110: begin
        dec_entry.ctrl[C_XORI] = 1'b1;
`ifdef DECODE_QUEUE_FUNCT_EN
        dec_entry.alu_op = 4'd4;
`endif
      end
      6'b100011: dec_entry.ctrl[C_LW] = 1'b1;
      6'b101011: dec_entry.ctrl[C_SW] = 1'b1;
      6'b000100: begin
        dec_entry.ctrl[C_BEQ] = 1'b1;
`ifdef DECODE_QUEUE_FUNCT_EN
        dec_entry.alu_op = 4'd1;
`endif
      end
      6'b000101: begin
        dec_entry.ctrl[C_BNE] = 1'b1;
`ifdef DECODE_QUEUE_FUNCT_EN
        dec_entry.alu_op = 4'd1;
`endif
      end
      6'b001111: begin
        dec_entry.ctrl[C_LUI] = 1'b1;
`ifdef DECODE_QUEUE_FUNCT_EN
        dec_entry.alu_op = 4'd8;
`endif
      end
      6'b000010: dec_entry.ctrl[C_J]   = 1'b1;
      6'b000011: dec_entry.ctrl[C_JAL] = 1'b1;
      default:   dec_entry.illegal     = 1'b1;
    endcase
  end

  // Entry storage: written on push, no reset needed since occupancy gates it
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_reg[wr_ptr_reg] <= dec_entry;
    end
  end

  // Pointers, occupancy and the saturating illegal counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      occ_reg         <= '0;
      illegal_cnt_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + 1'b1;
        2'b01:   occ_reg <= occ_reg - 1'b1;
        default: occ_reg <= occ_reg;
      endcase
      if (push && dec_entry.illegal && (illegal_cnt_reg != '1)) begin
        illegal_cnt_reg <= illegal_cnt_reg + 1'b1;
      end
    end
  end

  // Present the oldest entry, or all zeros when the queue is empty
  always_comb begin
    head_entry = mem_reg[rd_ptr_reg];
    if (!out_valid) begin
      head_entry = '0;
    end
  end

  assign out_ctrl    = head_entry.ctrl;
  assign out_illegal = head_entry.illegal;
  assign out_alu_op  = head_entry.alu_op;
  assign out_rs      = head_entry.rs;
  assign out_rt      = head_entry.rt;
  assign out_rd      = head_entry.rd;
  assign out_imm     = head_entry.imm;
  assign out_target  = head_entry.target;
  assign illegal_cnt = illegal_cnt_reg;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: a main instance (CNT_W=8) and a narrow
// counter instance (CNT_W=2) driven by the same stimulus.
module tb_decode_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_ctrl;
  logic        out_illegal;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rs, out_rt, out_rd;
  logic [15:0] out_imm;
  logic [25:0] out_target;
  logic [7:0]  illegal_cnt;

  logic        n_in_ready, n_out_valid, n_out_illegal;
  logic [11:0] n_out_ctrl;
  logic [3:0]  n_out_alu_op;
  logic [4:0]  n_out_rs, n_out_rt, n_out_rd;
  logic [15:0] n_out_imm;
  logic [25:0] n_out_target;
  logic [1:0]  n_illegal_cnt;

  int total = 0;
  int bad   = 0;

`ifdef DECODE_QUEUE_FUNCT_EN
  localparam bit FUNCT_EN = 1'b1;
`else
  localparam bit FUNCT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  decode_queue #(.QDEPTH(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_illegal(out_illegal), .out_alu_op(out_alu_op),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_imm(out_imm), .out_target(out_target), .illegal_cnt(illegal_cnt)
  );

  decode_queue #(.QDEPTH(2), .CNT_W(2)) dut_narrow (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(n_in_ready), .in_instr(in_instr),
    .out_valid(n_out_valid), .out_ready(out_ready),
    .out_ctrl(n_out_ctrl), .out_illegal(n_out_illegal), .out_alu_op(n_out_alu_op),
    .out_rs(n_out_rs), .out_rt(n_out_rt), .out_rd(n_out_rd),
    .out_imm(n_out_imm), .out_target(n_out_target), .illegal_cnt(n_illegal_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_ctrl", {20'd0, out_ctrl}, 32'd0);
    chk("rst_cnt", {24'd0, illegal_cnt}, 32'd0);
    chk("rst_rs", {27'd0, out_rs}, 32'd0);
    $display("txn reset: out_valid=%0d in_ready=%0d", out_valid, in_ready);

    // lw with consumer ready: visible one cycle later, then gone
    in_valid = 1'b1; in_instr = 32'h8C43_0004; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lw_valid", {31'd0, out_valid}, 32'd1);
    chk("lw_ctrl", {20'd0, out_ctrl}, 32'h020);
    chk("lw_rs", {27'd0, out_rs}, 32'd2);
    chk("lw_rt", {27'd0, out_rt}, 32'd3);
    chk("lw_imm", {16'd0, out_imm}, 32'h0004);
    chk("lw_illegal", {31'd0, out_illegal}, 32'd0);
    chk("lw_alu", {28'd0, out_alu_op}, 32'd0);
    $display("txn lw: ctrl=%h rs=%0d rt=%0d imm=%h", out_ctrl, out_rs, out_rt, out_imm);
    tick();
    chk("lw_drained", {31'd0, out_valid}, 32'd0);
    chk("empty_imm", {16'd0, out_imm}, 32'd0);

    // Fill to capacity with consumer stalled; third word must be held
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h2001_0005;   // addi
    tick();
    chk("fill1_in_ready", {31'd0, in_ready}, 32'd1);
    in_instr = 32'h3422_00FF;                    // ori
    tick();
    chk("fill2_in_ready", {31'd0, in_ready}, 32'd0);
    in_instr = 32'h0800_0010;                    // j
    tick();
    chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    chk("hold_ctrl", {20'd0, out_ctrl}, 32'h002);
    chk("hold_imm", {16'd0, out_imm}, 32'h0005);
    $display("txn full: head ctrl=%h imm=%h in_ready=%0d", out_ctrl, out_imm, in_ready);
    // Full: pop happens, push is blocked in the same cycle
    out_ready = 1'b1;
    tick();
    chk("drain_ori_ctrl", {20'd0, out_ctrl}, 32'h008);
    chk("drain_ori_rt", {27'd0, out_rt}, 32'd2);
    chk("drain_ori_imm", {16'd0, out_imm}, 32'h00FF);
    chk("after_pop_in_ready", {31'd0, in_ready}, 32'd1);
    tick();                                      // pop ori, push j
    in_valid = 1'b0;
    chk("drain_j_ctrl", {20'd0, out_ctrl}, 32'h400);
    chk("drain_j_target", {6'd0, out_target}, 32'h10);
    $display("txn drain: ctrl=%h target=%h", out_ctrl, out_target);
    tick();
    chk("drain_empty", {31'd0, out_valid}, 32'd0);

    // Half full: push and pop together keep occupancy and order
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h3003_0007;   // andi
    tick();
    out_ready = 1'b1; in_instr = 32'h3804_0009;  // xori
    tick();
    chk("pp_xori_ctrl", {20'd0, out_ctrl}, 32'h010);
    chk("pp_xori_rt", {27'd0, out_rt}, 32'd4);
    chk("pp_in_ready", {31'd0, in_ready}, 32'd1);
    in_instr = 32'h3C05_1234;                    // lui
    tick();
    chk("pp_lui_ctrl", {20'd0, out_ctrl}, 32'h200);
    chk("pp_lui_imm", {16'd0, out_imm}, 32'h1234);
    chk("pp_lui_alu", {28'd0, out_alu_op}, FUNCT_EN ? 32'd8 : 32'd0);
    $display("txn push_pop: ctrl=%h imm=%h", out_ctrl, out_imm);
    in_valid = 1'b0;
    tick();
    chk("pp_empty", {31'd0, out_valid}, 32'd0);

    // Illegal opcodes, five back-to-back pushes
    in_valid = 1'b1; in_instr = 32'hFC00_0000;
    tick();
    chk("ill_flag", {31'd0, out_illegal}, 32'd1);
    chk("ill_ctrl", {20'd0, out_ctrl}, 32'd0);
    chk("ill_cnt1", {24'd0, illegal_cnt}, 32'd1);
    tick(); tick(); tick(); tick();
    in_valid = 1'b0;
    chk("ill_cnt5", {24'd0, illegal_cnt}, 32'd5);
    chk("ill_cnt_sat", {30'd0, n_illegal_cnt}, 32'd3);
    $display("txn illegal: cnt=%0d narrow_cnt=%0d", illegal_cnt, n_illegal_cnt);
    tick();

    // R_type sub, bad funct, beq
    in_valid = 1'b1; in_instr = 32'h0085_1022;
    tick();
    chk("sub_ctrl", {20'd0, out_ctrl}, 32'h001);
    chk("sub_alu", {28'd0, out_alu_op}, FUNCT_EN ? 32'd1 : 32'd0);
    chk("sub_rd", {27'd0, out_rd}, 32'd2);
    chk("sub_rs", {27'd0, out_rs}, 32'd4);
    $display("txn sub: ctrl=%h alu=%0d rd=%0d", out_ctrl, out_alu_op, out_rd);
    in_instr = 32'h0085_103F;
    tick();
    chk("badfn_illegal", {31'd0, out_illegal}, FUNCT_EN ? 32'd1 : 32'd0);
    chk("badfn_ctrl", {20'd0, out_ctrl}, FUNCT_EN ? 32'd0 : 32'h001);
    chk("badfn_cnt", {24'd0, illegal_cnt}, FUNCT_EN ? 32'd6 : 32'd5);
    $display("txn bad_funct: illegal=%0d ctrl=%h", out_illegal, out_ctrl);
    in_instr = 32'h1085_0003;                    // beq
    tick();
    in_valid = 1'b0;
    chk("beq_ctrl", {20'd0, out_ctrl}, 32'h080);
    chk("beq_alu", {28'd0, out_alu_op}, FUNCT_EN ? 32'd1 : 32'd0);
    tick();

    // Reset mid-stream with two entries queued
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h8C43_0004;
    tick();
    in_instr = 32'hFC00_0000;
    tick();
    chk("prerst_full", {31'd0, in_ready}, 32'd0);
    rst = 1'b1; out_ready = 1'b1; in_instr = 32'h2001_0005;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_cnt", {24'd0, illegal_cnt}, 32'd0);
    chk("midrst_ncnt", {30'd0, n_illegal_cnt}, 32'd0);
    chk("midrst_ctrl", {20'd0, out_ctrl}, 32'd0);
    tick();
    chk("midrst_still_empty", {31'd0, out_valid}, 32'd0);
    $display("txn mid_reset: out_valid=%0d in_ready=%0d cnt=%0d", out_valid, in_ready, illegal_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
